// File: rtl/move_controller_pkg.sv
// Shared definitions for the 2048 move sequencer: direction bit positions,
// FSM state encoding, spawn value codes and small combinational helpers.
package move_controller_pkg;

    localparam int BOARD_CELLS = 16;

    // Direction bit positions on btn_dir / ready_to_board / move_done
    localparam int DIR_LEFT  = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_RIGHT = 2;
    localparam int DIR_UP    = 3;

    // Tile value codes driven to the board (log2 of the tile)
    localparam logic [3:0] VAL_TILE2 = 4'd1;
    localparam logic [3:0] VAL_TILE4 = 4'd2;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_PICK   = 3'd4,
        ST_SPAWN  = 3'd5,
        ST_SETTLE = 3'd6,
        ST_OVER   = 3'd7
    } mc_state_e;

    // One step of the spawn LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    // True when exactly one of the four direction bits is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Bit index of a one-hot direction vector
    function automatic logic [1:0] dir_index(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/move_controller_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick spawn cells and tile values.
// It steps every cycle so spawn choices depend on when the player presses.
module move_controller_lfsr16
    import move_controller_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    // LFSR state: reload the seed on reset, otherwise advance one step
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/move_controller.sv
// Upstream sequencer for the 2048 board: issues one-hot move requests,
// waits for the board to settle, then spawns a 2/4 tile on a pseudo-random
// empty cell. Also seeds the start tiles after reset and flags game-over.
// All outputs are registered, decoded from the next state.
module move_controller
    import move_controller_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          INIT_TILES   = 2,
    parameter int          MOVE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_dir,
    input  logic [15:0] occupied,
    input  logic [3:0]  move_done,
    output logic [3:0]  ready_to_board,
    output logic        preset_ext,
    output logic [3:0]  preset_location,
    output logic [3:0]  value_from_preset,
    output logic        busy,
    output logic        game_over
);

    localparam int TMO_W = $clog2(MOVE_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOVE_TIMEOUT - 1);

    logic [15:0]      lfsr_s;

    mc_state_e        state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [15:0]      occ_q, occ_d;
    logic [3:0]       scan_q, scan_d;
    logic [3:0]       scan_cnt_q, scan_cnt_d;
    logic [3:0]       chosen_q, chosen_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [4:0]       spawn_cnt_q, spawn_cnt_d;
    logic             fill_q, fill_d;

    logic [3:0]       ready_q, ready_d;
    logic             preset_q, preset_d;
    logic [3:0]       loc_q, loc_d;
    logic [3:0]       val_q, val_d;
    logic             busy_q, busy_d;
    logic             over_q, over_d;

    move_controller_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr16 (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    // Next-state logic: sequencing, occupancy snapshot, scan and timeout counters
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        occ_d       = occ_q;
        scan_d      = scan_q;
        scan_cnt_d  = scan_cnt_q;
        chosen_d    = chosen_q;
        tmo_d       = tmo_q;
        spawn_cnt_d = spawn_cnt_q;
        fill_d      = fill_q;
        case (state_q)
            ST_INIT: begin
                if (spawn_cnt_q < 5'(INIT_TILES)) begin
                    state_d    = ST_PICK;
                    fill_d     = 1'b1;
                    scan_d     = lfsr_s[3:0];
                    scan_cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                    fill_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (is_onehot4(btn_dir)) begin
                    state_d = ST_MOVE;
                    dir_d   = dir_index(btn_dir);
                    occ_d   = occupied;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (move_done[dir_q] || (tmo_q == TMO_LAST)) begin
                    state_d = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                // A move that left the board untouched earns no new tile
                if (occupied == occ_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_PICK;
                    scan_d     = lfsr_s[3:0];
                    scan_cnt_d = 4'd0;
                end
            end
            ST_PICK: begin
                if (!occupied[scan_q]) begin
                    state_d  = ST_SPAWN;
                    chosen_d = scan_q;
                end else if (scan_cnt_q == 4'd15) begin
                    state_d = ST_OVER;
                end else begin
                    scan_d     = scan_q + 4'd1;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end
            ST_SPAWN: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (fill_q) begin
                    spawn_cnt_d = spawn_cnt_q + 5'd1;
                    state_d     = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    // The tile value uses the LFSR value that will be live in the SPAWN cycle.
    always_comb begin
        ready_d  = 4'd0;
        preset_d = 1'b0;
        loc_d    = 4'd0;
        val_d    = 4'd0;
        busy_d   = 1'b1;
        over_d   = 1'b0;
        case (state_d)
            ST_MOVE: begin
                ready_d = 4'd1 << dir_d;
            end
            ST_SPAWN: begin
                preset_d = 1'b1;
                loc_d    = chosen_d;
                if ((lfsr_step(lfsr_s) & 16'h00F0) == 16'h0000) begin
                    val_d = VAL_TILE4;
                end else begin
                    val_d = VAL_TILE2;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_OVER: begin
                busy_d = 1'b0;
                over_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            dir_q       <= 2'd0;
            occ_q       <= 16'd0;
            scan_q      <= 4'd0;
            scan_cnt_q  <= 4'd0;
            chosen_q    <= 4'd0;
            tmo_q       <= '0;
            spawn_cnt_q <= 5'd0;
            fill_q      <= 1'b0;
            ready_q     <= 4'd0;
            preset_q    <= 1'b0;
            loc_q       <= 4'd0;
            val_q       <= 4'd0;
            busy_q      <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            occ_q       <= occ_d;
            scan_q      <= scan_d;
            scan_cnt_q  <= scan_cnt_d;
            chosen_q    <= chosen_d;
            tmo_q       <= tmo_d;
            spawn_cnt_q <= spawn_cnt_d;
            fill_q      <= fill_d;
            ready_q     <= ready_d;
            preset_q    <= preset_d;
            loc_q       <= loc_d;
            val_q       <= val_d;
            busy_q      <= busy_d;
            over_q      <= over_d;
        end
    end

    assign ready_to_board    = ready_q;
    assign preset_ext        = preset_q;
    assign preset_location   = loc_q;
    assign value_from_preset = val_q;
    assign busy              = busy_q;
    assign game_over         = over_q;

endmodule
